// File: rtl/rotl_seq.sv
// Sequential left rotator: captures a word and amount on Start, rotates left one
// bit per clock until the amount is consumed, then pulses Done for one cycle.
module rotl_seq #(
  parameter int WIDTH = 4,
  parameter int SW    = 2
) (
  input  logic             i_clock,
  input  logic             i_resetn,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [SW-1:0]    i_shift,
  output logic [WIDTH-1:0] o_y,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ROTATE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_data;
  logic [SW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_rotl1;

  assign w_rotl1 = {r_data[WIDTH-2:0], r_data[WIDTH-1]};

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_data  <= i_a;
            r_cnt   <= i_shift;
            r_state <= (i_shift != '0) ? S_ROTATE : S_DONE;
          end
        end
        S_ROTATE: begin
          // CNT==1 here means this edge performs the final rotation
          r_data <= w_rotl1;
          r_cnt  <= r_cnt - SW'(1);
          if (r_cnt == SW'(1)) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_y    = r_data;
  assign o_busy = (r_state == S_ROTATE) || (r_state == S_DONE);
  assign o_done = (r_state == S_DONE);

endmodule

// File: tb/tb_rotl_seq.sv
// Directed bench for rotl_seq: reset, single ops, Start held during busy,
// mid-rotate reset, and rotate-right/rotate-left inverse sweep.
module tb_rotl_seq;

  logic       clock;
  logic       resetn;
  logic       start;
  logic [3:0] a;
  logic [1:0] shift;
  logic [3:0] y;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  rotl_seq #(.WIDTH(4), .SW(2)) dut (
    .i_clock (clock),
    .i_resetn(resetn),
    .i_start (start),
    .i_a     (a),
    .i_shift (shift),
    .o_y     (y),
    .o_busy  (busy),
    .o_done  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] rotr4(input logic [3:0] x, input int s);
    logic [3:0] t;
    t = x;
    for (int i = 0; i < s; i++) t = {t[0], t[3:1]};
    return t;
  endfunction

  // One full operation with amount k; inputs driven and outputs sampled on negedges
  task automatic run_op(input string tag, input logic [3:0] av, input logic [1:0] sv,
                        input logic [3:0] exp_y);
    @(negedge clock);
    start = 1'b1; a = av; shift = sv;
    @(negedge clock);
    start = 1'b0; a = 4'h0; shift = 2'd0;
    chk({tag, "_busy_rise"}, busy, 1);
    for (int i = 0; i < int'(sv); i++) begin
      chk({tag, "_done_early"}, done, 0);
      @(negedge clock);
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_y"}, y, exp_y);
    @(negedge clock);
    chk({tag, "_busy_fall"}, busy, 0);
    chk({tag, "_done_fall"}, done, 0);
    chk({tag, "_y_hold"}, y, exp_y);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b1; a = 4'hF; shift = 2'd3;

    // Reset held with Start asserted: nothing captured
    repeat (3) begin
      @(negedge clock);
      chk("rst_y", y, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
    resetn = 1'b1; start = 1'b0;

    run_op("r1001_s1", 4'b1001, 2'd1, 4'b0011);
    run_op("r0001_s3", 4'b0001, 2'd3, 4'b1000);
    run_op("r0110_s0", 4'b0110, 2'd0, 4'b0110);

    // Start held high while busy with changing A/Shift
    @(negedge clock);
    start = 1'b1; a = 4'b0011; shift = 2'd2;
    @(negedge clock);
    chk("hold_busy_e0", busy, 1);
    chk("hold_done_e0", done, 0);
    a = 4'b1111; shift = 2'd1;
    @(negedge clock);
    chk("hold_done_e1", done, 0);
    a = 4'b0101; shift = 2'd3;
    @(negedge clock);
    chk("hold_done_e2", done, 1);
    chk("hold_y_e2", y, 4'b1100);
    a = 4'b1110; shift = 2'd1;
    @(negedge clock);
    chk("hold_busy_e3", busy, 0);
    chk("hold_y_e3", y, 4'b1100);
    a = 4'b0100; shift = 2'd1;
    @(negedge clock);
    chk("hold_busy_e4", busy, 1);
    chk("hold_done_e4", done, 0);
    start = 1'b0;
    @(negedge clock);
    chk("hold_done_e5", done, 1);
    chk("hold_y_e5", y, 4'b1000);
    @(negedge clock);
    chk("hold_busy_e6", busy, 0);

    // Reset mid-rotate: asynchronous clear, no Done afterwards
    @(negedge clock);
    start = 1'b1; a = 4'b1011; shift = 2'd3;
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_y", y, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    repeat (4) begin
      @(negedge clock);
      chk("mid_rst_no_done", done, 0);
    end
    resetn = 1'b1;
    run_op("post_rst", 4'b1011, 2'd3, 4'b1101);

    // Inverse of right rotation over every word and amount
    for (int av = 0; av < 16; av++) begin
      for (int s = 0; s < 4; s++) begin
        run_op("inv", rotr4(4'(av), s), 2'(s), 4'(av));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rotl_seq.md
# rotl_seq

Sequential left rotator for the shifter datapath. It is the inverse-direction partner of the combinational 4-bit mux-based right rotator. It accepts a word and a rotate amount on a start strobe, then rotates the held word left by one bit position per clock until the amount is consumed. It reports completion with a one-cycle Done pulse, so feeding it a right-rotator's output with the same amount recovers the original word.

## Interface
- WIDTH, 4, data word width in bits (≥2).
- SW, 2, width of rotate-amount field; amounts 0..2^SW−1; WIDTH must be ≥ 2^SW... amounts ≥ WIDTH wrap naturally (rotation mod WIDTH).
- Clock  input  1  single clock; all state updates on rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- Start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  word to rotate; captured on accepted Start.
- Shift  input  SW  rotate-left amount; captured on accepted Start.
- Y  output  WIDTH  rotation register; valid when Done=1 and held until next accepted Start.
- Busy  output  1  high in ROTATE and DONE; Start ignored while high.
- Done  output  1  one-cycle completion pulse.

## Operation
- Internal: data register R (drives Y), down-counter CNT (SW bits), state register.
- States: IDLE, ROTATE, DONE.
- IDLE: on Start=1, R<=A and CNT<=Shift. Next state is ROTATE if Shift≠0, else DONE. Start=0 holds all registers.
- ROTATE: each cycle R<={R[WIDTH-2:0],R[WIDTH-1]} and CNT<=CNT−1. When CNT==1 at the edge, the final rotation occurs and the next state is DONE.
- DONE: Done=1 for exactly this cycle; R unchanged. Next state is IDLE unconditionally. Start during DONE is ignored.
- Busy and Done are decoded from state (Moore outputs), with no combinational path from inputs.
- Y=R at all times; only guaranteed meaningful while Done=1 or afterward in IDLE.
- Shift=0 performs no rotation: Y=A.
- Start/A/Shift changes while Busy have no effect on the operation in flight.
- Reset asserted at any time (including mid-ROTATE) forces state IDLE, R=0, CNT=0 immediately and asynchronously. The operation is abandoned and no Done is issued.

## Timing
- Reset values: Y=0, Busy=0, Done=0, state IDLE.
- Let edge 0 be the rising edge that samples Start=1 in IDLE, and k=Shift.
- Busy rises after edge 0.
- Rotations happen on edges 1..k. Done=1 in the cycle after edge k (k=0: the cycle after edge 0).
- Busy falls and Done falls after edge k+1; Start is accepted again from edge k+2.
- Total occupancy is k+2 cycles from accept to next possible accept.
- Back-to-back throughput: one operation per k+2 cycles; there is no pipelining.
- Reset release: first Start is sampled on the first rising edge with Resetn=1.

## Test plan
- Reset: hold Resetn=0 with Start=1, A=4'hF. Required: Y=0, Busy=0, Done=0 throughout; no capture.
- A=4'b1001, Shift=1, Start pulse. Required: Busy after edge 0; Done=1 in the cycle after edge 1 with Y=4'b0011; Busy=0 after edge 2.
- A=4'b0001, Shift=3. Required: Done in the cycle after edge 3, Y=4'b1000. Then Shift=0, A=4'b0110: Done in the cycle after edge 0, Y=4'b0110.
- Start held high with changing A/Shift during ROTATE and DONE. Required: result reflects only the first captured pair. The next operation starts at edge k+2 using the values present then.
- A=4'b1011, Shift=3, drive Resetn=0 after edge 1. Required: Y=0, Busy=0 asynchronously; no Done pulse. After release, a new Start completes normally.
- Exhaustive inverse check: for all 16 A and 4 amounts, apply A rotated right by S with Shift=S. Required: Y=A at every Done.
